// File: rtl/writeback_arbiter.sv
// Single register_file write port shared by the in-order pipeline writeback and
// a small FIFO of late results, with pending-register mask and forwarding lookup.
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_write_enable,
  input  logic [4:0]  pipe_write_address,
  input  logic [31:0] pipe_write_data,
  input  logic        late_valid,
  output logic        late_ready,
  input  logic [4:0]  late_address,
  input  logic [31:0] late_data,
  output logic        write_enable,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  output logic [31:0] pending_mask,
  input  logic [4:0]  query_address,
  output logic        query_hit,
  output logic [31:0] query_data
);

  logic [4:0]       entry_addr [DEPTH];
  logic [31:0]      entry_data [DEPTH];
  logic [DEPTH-1:0] entry_live;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic [PTR_W-1:0] slot;

  logic pipe_hit;
  logic late_fire;
  logic push;
  logic not_empty;
  logic head_live;
  logic pop;

  assign late_ready = count < (PTR_W+1)'(DEPTH);
  assign pipe_hit   = pipe_write_enable && (pipe_write_address != 5'd0);
  assign late_fire  = late_valid && late_ready;
  // Writes to r0 complete the handshake but are dropped here.
  assign push       = late_fire && (late_address != 5'd0);
  assign not_empty  = count != '0;
  assign head_live  = not_empty && entry_live[head];
  // A dead head always leaves; a live head only leaves when the pipe is idle.
  assign pop        = not_empty && !(head_live && pipe_hit);

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_nxt = count - (PTR_W+1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; later assignments to the same live bit take precedence.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      entry_live <= '0;
    end else begin
      // The pipe write is younger than everything buffered, so it kills matches.
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_hit && (entry_addr[i] == pipe_write_address)) begin
          entry_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        entry_live[head] <= 1'b0;
        head             <= head + PTR_W'(1);
      end
      if (push) begin
        entry_live[tail] <= !(pipe_hit && (late_address == pipe_write_address));
        tail             <= tail + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

  // NOTE: the payload storage is deliberately not reset; the live bits alone
  // decide whether an entry means anything.
  always_ff @(posedge clock) begin
    if (push) begin
      entry_addr[tail] <= late_address;
      entry_data[tail] <= late_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else if (pipe_hit) begin
      write_enable  <= 1'b1;
      write_address <= pipe_write_address;
      write_data    <= pipe_write_data;
    end else if (head_live) begin
      write_enable  <= 1'b1;
      write_address <= entry_addr[head];
      write_data    <= entry_data[head];
    end else begin
      write_enable  <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  // Walking oldest to newest lets the newest match overwrite older ones.
  always_comb begin
    pending_mask = '0;
    query_hit    = 1'b0;
    query_data   = '0;
    slot         = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (entry_live[slot]) begin
        pending_mask[entry_addr[slot]] = 1'b1;
        if ((query_address != 5'd0) && (entry_addr[slot] == query_address)) begin
          query_hit  = 1'b1;
          query_data = entry_data[slot];
        end
      end
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed plus randomized bench for writeback_arbiter, checked against a
// queue-based model of the late-result buffer.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        pipe_write_enable;
  logic [4:0]  pipe_write_address;
  logic [31:0] pipe_write_data;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_address;
  logic [31:0] late_data;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [4:0]  query_address;
  logic        query_hit;
  logic [31:0] query_data;

  writeback_arbiter #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clock              (clock),
    .reset              (reset),
    .pipe_write_enable  (pipe_write_enable),
    .pipe_write_address (pipe_write_address),
    .pipe_write_data    (pipe_write_data),
    .late_valid         (late_valid),
    .late_ready         (late_ready),
    .late_address       (late_address),
    .late_data          (late_data),
    .write_enable       (write_enable),
    .write_address      (write_address),
    .write_data         (write_data),
    .pending_mask       (pending_mask),
    .query_address      (query_address),
    .query_hit          (query_hit),
    .query_data         (query_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  bit          model_valid = 1'b0;
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Buffer behaviour per edge: output choice, dead-head drop, kill, then enqueue.
  task automatic model_edge();
    bit pipe_w;
    bit rdy;
    if (!reset) begin
      q.delete();
      exp_we = 1'b0;
      exp_wa = '0;
      exp_wd = '0;
      model_valid = 1'b1;
      return;
    end
    pipe_w = pipe_write_enable && (pipe_write_address != 0);
    rdy    = q.size() < DEPTH;
    if (pipe_w) begin
      exp_we = 1'b1;
      exp_wa = pipe_write_address;
      exp_wd = pipe_write_data;
      if (q.size() > 0 && !q[0].live) void'(q.pop_front());
    end else if (q.size() > 0 && q[0].live) begin
      exp_we = 1'b1;
      exp_wa = q[0].addr;
      exp_wd = q[0].data;
      void'(q.pop_front());
    end else begin
      exp_we = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (pipe_w) begin
      foreach (q[i]) if (q[i].addr == pipe_write_address) q[i].live = 1'b0;
    end
    if (late_valid && rdy && late_address != 0) begin
      q.push_back('{late_address, late_data, !(pipe_w && late_address == pipe_write_address)});
    end
  endtask

  task automatic cycle();
    logic [31:0] m_mask;
    logic        m_hit;
    logic [31:0] m_data;
    #1;
    if (model_valid) begin
      m_mask = '0;
      m_hit  = 1'b0;
      m_data = '0;
      foreach (q[i]) begin
        if (q[i].live) begin
          if (q[i].addr != 0) m_mask = m_mask | (32'd1 << q[i].addr);
          if (query_address != 0 && q[i].addr == query_address) begin
            m_hit  = 1'b1;
            m_data = q[i].data;
          end
        end
      end
      check("late_ready", {31'd0, late_ready}, {31'd0, (q.size() < DEPTH)});
      check("pending_mask", pending_mask, m_mask);
      check("query_hit", {31'd0, query_hit}, {31'd0, m_hit});
      check("query_data", query_data, m_data);
    end
    @(posedge clock);
    model_edge();
    #1;
    check("write_enable", {31'd0, write_enable}, {31'd0, exp_we});
    check("write_address", {27'd0, write_address}, {27'd0, exp_wa});
    check("write_data", write_data, exp_wd);
  endtask

  task automatic set_pipe(input logic en, input logic [4:0] a, input logic [31:0] d);
    pipe_write_enable  = en;
    pipe_write_address = a;
    pipe_write_data    = d;
  endtask

  task automatic set_late(input logic v, input logic [4:0] a, input logic [31:0] d);
    late_valid   = v;
    late_address = a;
    late_data    = d;
  endtask

  task automatic idle(input int n);
    set_pipe(1'b0, 5'd0, 32'd0);
    set_late(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int    got[$];
    int    k;
    bit    rdy;
    int    bad7;
    reset = 1'b0;
    query_address = 5'd0;
    set_pipe(1'b0, 5'd0, 32'd0);
    set_late(1'b0, 5'd0, 32'd0);

    // Reset state
    cycle();
    check("rst_we", {31'd0, write_enable}, 32'd0);
    check("rst_wa", {27'd0, write_address}, 32'd0);
    check("rst_wd", write_data, 32'd0);
    reset = 1'b1;
    idle(1);

    // Pipe write r5 shows up one cycle later, then the port goes idle
    set_pipe(1'b1, 5'd5, 32'h1234_5678);
    cycle();
    check("pipe_we", {31'd0, write_enable}, 32'd1);
    check("pipe_wa", {27'd0, write_address}, 32'd5);
    check("pipe_wd", write_data, 32'h1234_5678);
    idle(1);
    check("pipe_we_off", {31'd0, write_enable}, 32'd0);

    // Late r9 with pipe idle
    set_late(1'b1, 5'd9, 32'hDEAD_BEEF);
    #1;
    check("r9_ready", {31'd0, late_ready}, 32'd1);
    cycle();
    set_late(1'b0, 5'd0, 32'd0);
    query_address = 5'd9;
    #1;
    check("r9_mask", pending_mask, 32'h0000_0200);
    check("r9_hit", {31'd0, query_hit}, 32'd1);
    check("r9_qdata", query_data, 32'hDEAD_BEEF);
    cycle();
    check("r9_wa", {27'd0, write_address}, 32'd9);
    check("r9_wd", write_data, 32'hDEAD_BEEF);
    check("r9_mask_clr", pending_mask, 32'd0);
    idle(1);

    // Pipe r1..r6 back to back while late r10..r14 are offered
    k = 10;
    for (int c = 0; c < 16; c++) begin
      if (c < 6) set_pipe(1'b1, 5'(c + 1), 32'h100 + 32'(c));
      else       set_pipe(1'b0, 5'd0, 32'd0);
      if (k <= 14) set_late(1'b1, 5'(k), 32'h1000 + 32'(k));
      else         set_late(1'b0, 5'd0, 32'd0);
      #1;
      rdy = late_ready;
      if (c <= 3 || c == 7) check("burst_ready_hi", {31'd0, late_ready}, 32'd1);
      if (c >= 4 && c <= 6) check("burst_ready_lo", {31'd0, late_ready}, 32'd0);
      cycle();
      if (rdy && late_valid) k++;
      if (c >= 6 && write_enable) got.push_back(int'(write_address));
    end
    check("burst_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check("burst_order", 32'(got[i]), 32'(10 + i));
    end
    idle(2);

    // Late r7 killed by a younger pipe write to r7
    bad7 = 0;
    set_pipe(1'b1, 5'd20, 32'h20);
    set_late(1'b1, 5'd7, 32'h0000_AAAA);
    cycle();
    set_late(1'b0, 5'd0, 32'd0);
    set_pipe(1'b1, 5'd7, 32'h0000_BBBB);
    #1;
    check("r7_mask_set", pending_mask, 32'h0000_0080);
    cycle();
    check("r7_mask_clr", pending_mask, 32'd0);
    check("r7_wd", write_data, 32'h0000_BBBB);
    set_pipe(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (write_enable && write_address == 5'd7 && write_data != 32'h0000_BBBB) bad7++;
    end
    check("r7_no_stale", 32'(bad7), 32'd0);

    // Two late entries to r3: newest forwarded, both written in order
    set_pipe(1'b1, 5'd20, 32'h20);
    set_late(1'b1, 5'd3, 32'h1);
    cycle();
    set_pipe(1'b1, 5'd21, 32'h21);
    set_late(1'b1, 5'd3, 32'h2);
    cycle();
    set_pipe(1'b0, 5'd0, 32'd0);
    set_late(1'b0, 5'd0, 32'd0);
    query_address = 5'd3;
    #1;
    check("r3_hit", {31'd0, query_hit}, 32'd1);
    check("r3_newest", query_data, 32'h2);
    cycle();
    check("r3_first_wa", {27'd0, write_address}, 32'd3);
    check("r3_first_wd", write_data, 32'h1);
    cycle();
    check("r3_second_wa", {27'd0, write_address}, 32'd3);
    check("r3_second_wd", write_data, 32'h2);
    idle(1);

    // Late r0 is accepted and dropped
    set_late(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check("r0_ready", {31'd0, late_ready}, 32'd1);
    cycle();
    set_late(1'b0, 5'd0, 32'd0);
    #1;
    check("r0_mask", pending_mask, 32'd0);
    cycle();
    check("r0_no_write", {31'd0, write_enable}, 32'd0);

    // Reset with three buffered entries discards them
    set_pipe(1'b1, 5'd20, 32'h20);
    for (int i = 1; i <= 3; i++) begin
      set_late(1'b1, 5'(i), 32'h300 + 32'(i));
      cycle();
    end
    set_pipe(1'b0, 5'd0, 32'd0);
    set_late(1'b0, 5'd0, 32'd0);
    #1;
    check("pre_rst_mask", pending_mask, 32'h0000_000E);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    check("post_rst_mask", pending_mask, 32'd0);
    check("post_rst_ready", {31'd0, late_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post_rst_no_write", {31'd0, write_enable}, 32'd0);
    end

    // Randomized traffic with narrow address ranges to force collisions
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      set_pipe(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom);
      set_late(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
      query_address = 5'($urandom_range(0, 7));
      cycle();
    end
    reset = 1'b1;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Owns the single register_file write port and merges two writer sources onto it.
- Source 1 is the in-order pipeline writeback (MEM/WB). It is always accepted and has the highest priority.
- Source 2 is late results from multi-cycle units (divider, uncached load). They arrive over a valid/ready handshake and are buffered in a small FIFO.
- The block exports a pending-register mask and a forwarding lookup so decode can stall or bypass on buffered results.

Parameters:
- DEPTH, 4, number of late-result FIFO entries (power of two, at least 2).
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- pipe_write_enable  in  1  pipeline writeback valid this cycle.
- pipe_write_address  in  5  pipeline destination register.
- pipe_write_data  in  32  pipeline result.
- late_valid  in  1  late unit presents a result.
- late_ready  out  1  block accepts a late result this cycle.
- late_address  in  5  late destination register.
- late_data  in  32  late result.
- write_enable  out  1  register_file write enable (registered).
- write_address  out  5  register_file write address (registered).
- write_data  out  32  register_file write data (registered).
- pending_mask  out  32  bit r = 1 if a live FIFO entry targets register r; bit 0 is always 0.
- query_address  in  5  forwarding lookup address.
- query_hit  out  1  a live FIFO entry matches query_address (never for 0).
- query_data  out  32  data of the newest matching live entry; 0 if no hit.

Behaviour:
- Reset (reset==0 at an edge):
  - FIFO emptied and all entry live bits cleared.
  - write_enable, write_address and write_data all go to 0.
  - Reset mid-operation discards buffered results without writing them.
- Address 0: pipeline writes to 0 are ignored. Late results to 0 are accepted by the handshake and then discarded (not enqueued).
- late_ready is 1 when the registered count is below DEPTH. A transfer happens when late_valid && late_ready.
- Enqueue: the entry is stored at the tail with live=1 and count increments.
- Kill rule: a pipeline write to R (R≠0) is younger than every buffered entry. On that edge it clears live on all entries with address R. If an entry to R is enqueued on the same edge, it is enqueued already killed.
- Output-register selection each edge, in priority order:
  - (a) pipe_write_enable && address≠0: output loads the pipe write, with write_enable=1.
  - (b) otherwise, if the FIFO head is live: head is popped and output loads it, with write_enable=1.
  - (c) otherwise: write_enable=0, and address/data hold their previous values.
- A dead head is popped on any edge, regardless of the pipe. It produces no write.
- Simultaneous push and pop on one edge leaves count unchanged.
- Latency:
  - A pipe write appears on the write port 1 cycle later.
  - A late result accepted at edge N is visible in pending_mask/query after N. Its earliest write-port appearance is after edge N+1.
- Starvation: a continuous pipe write stream holds the FIFO. This is acceptable because the hazard unit stalls on pending_mask.
- pending_mask, query_hit and query_data are combinational from FIFO state only.
  - Entries sitting in the output register are not covered; register_file's write bypass covers them.
  - Newest means the match closest to the tail.
- Count range is 0..DEPTH. Pointers wrap modulo DEPTH.

Test Plan:
- Reset, then pipe write r5=0x1234_5678 → next cycle write_enable=1, addr=5, data=0x12345678; the cycle after, write_enable=0.
- Late r9=0xDEAD_BEEF with pipe idle → accepted; pending_mask=0x0000_0200; query 9 hits 0xDEADBEEF. Next edge writes r9 and the mask returns to 0.
- Pipe writes r1..r6 on consecutive cycles while late r10, r11, r12, r13, r14 are offered:
  - late_ready drops after 4 accepts;
  - the FIFO drains in order r10..r13 once the pipe goes idle;
  - r14 is accepted when space frees.
- Late r7=0xAAAA buffered while a pipe write r7=0xBBBB is blocking → the entry is killed, the mask bit clears, and only 0xBBBB is ever written to r7.
- Two late entries to r3 (0x1 then 0x2) → query 3 returns 0x2; both writes are issued in order.
- Late r0=0xFFFF_FFFF → late_ready handshake completes; no enqueue, mask stays 0, no write. Reset asserted with 3 entries buffered → count=0, no writes after reset.
